axil_reg_slave: RTL and testbench

AXI4-Lite responder that terminates the PS general-purpose master port (M00_AXI) inside the fabric and exposes a flat register file. Writable control words drive ADC-domain logic. Read-only status words sample fabric signals. It sits directly on the `M00_AXI_*` nets of `system_wrapper` and runs entirely on `axi_clock`.

---
 rtl/axil_reg_pkg.sv | 22 ++
 rtl/axil_reg_slave.sv | 197 +++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg
// Shared definitions for the AXI4-Lite register slave:
//   RESP_OKAY / RESP_SLVERR / RESP_DECERR  AXI response codes
//   strb_merge(old, data, strb)            byte-lane merge of a write into a stored word
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte k of the result comes from data when strb[k] is set, otherwise from old.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = strb[k] ? data[8*k +: 8] : old[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// axil_reg_slave
// AXI4-Lite responder exposing a flat register file on axi_clock.
//   Words 0..N_RW-1          read/write control words, driven out on ctrl_o
//   Words N_RW..N_RW+N_RO-1  read-only status words sampled from status_i
//   Anything above           DECERR on both read and write
// Ports:
//   axi_clock, rst           clock, synchronous active-high reset
//   S_AXI_aw*/w*/b*          write address / data / response channels
//   S_AXI_ar*/r*             read address / data channels (*prot ignored)
//   ctrl_o                   control words, word i at [32i+31:32i]
//   wr_pulse_o               one-cycle pulse per control word after its commit
//   status_i                 status words, synchronous to axi_clock
//   rd_pulse_o               one-cycle pulse per status word when it is read
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int N_RW  = 8,
  parameter int N_RO  = 8,
  parameter int IDX_W = 10
) (
  input  logic                 axi_clock,
  input  logic                 rst,
  input  logic [31:0]          S_AXI_awaddr,
  input  logic [2:0]           S_AXI_awprot,
  input  logic                 S_AXI_awvalid,
  output logic                 S_AXI_awready,
  input  logic [31:0]          S_AXI_wdata,
  input  logic [3:0]           S_AXI_wstrb,
  input  logic                 S_AXI_wvalid,
  output logic                 S_AXI_wready,
  output logic [1:0]           S_AXI_bresp,
  output logic                 S_AXI_bvalid,
  input  logic                 S_AXI_bready,
  input  logic [31:0]          S_AXI_araddr,
  input  logic [2:0]           S_AXI_arprot,
  input  logic                 S_AXI_arvalid,
  output logic                 S_AXI_arready,
  output logic [31:0]          S_AXI_rdata,
  output logic [1:0]           S_AXI_rresp,
  output logic                 S_AXI_rvalid,
  input  logic                 S_AXI_rready,
  output logic [N_RW*32-1:0]   ctrl_o,
  output logic [N_RW-1:0]      wr_pulse_o,
  input  logic [N_RO*32-1:0]   status_i,
  output logic [N_RO-1:0]      rd_pulse_o
);

  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [31:0]       ctrl_q [N_RW];
  logic [N_RW-1:0]   wr_pulse_q;

  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [N_RO-1:0]   rd_pulse_q;

  // Upper address bits, byte offset and prot are intentionally not decoded.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot,
                       S_AXI_awaddr[31:IDX_W+2], S_AXI_awaddr[1:0],
                       S_AXI_araddr[31:IDX_W+2], S_AXI_araddr[1:0]};

  // Readies depend on registered state only.
  assign S_AXI_awready = !aw_held && !bvalid_q;
  assign S_AXI_wready  = !w_held && !bvalid_q;
  assign S_AXI_arready = !rvalid_q;

  assign S_AXI_bvalid = bvalid_q;
  assign S_AXI_bresp  = bresp_q;
  assign S_AXI_rvalid = rvalid_q;
  assign S_AXI_rdata  = rdata_q;
  assign S_AXI_rresp  = rresp_q;
  assign wr_pulse_o   = wr_pulse_q;
  assign rd_pulse_o   = rd_pulse_q;

  for (genvar gi = 0; gi < N_RW; gi++) begin : g_ctrl
    assign ctrl_o[32*gi +: 32] = ctrl_q[gi];
  end

  // ---------------- write channel ----------------
  logic              aw_hs, w_hs, commit;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;

  assign aw_hs = S_AXI_awvalid && S_AXI_awready;
  assign w_hs  = S_AXI_wvalid && S_AXI_wready;
  // A handshake on this edge counts as "present" so AW+W together commit at once.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_awaddr[IDX_W+1:2];
  assign wr_data = w_held ? w_data_q : S_AXI_wdata;
  assign wr_strb = w_held ? w_strb_q : S_AXI_wstrb;

  always_comb begin
    wr_resp = RESP_DECERR;
    if (wr_idx < IDX_W'(N_RW)) begin
      wr_resp = RESP_OKAY;
    end else if (wr_idx < IDX_W'(N_RW + N_RO)) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < N_RW; i++) ctrl_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (bvalid_q && S_AXI_bready) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        for (int i = 0; i < N_RW; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            ctrl_q[i]     <= strb_merge(ctrl_q[i], wr_data, wr_strb);
            wr_pulse_q[i] <= 1'b1;
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= S_AXI_awaddr[IDX_W+1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_wdata;
          w_strb_q <= S_AXI_wstrb;
        end
      end
    end
  end

  // ---------------- read channel ----------------
  logic              ar_hs;
  logic [IDX_W-1:0]  ar_idx;
  logic [31:0]       rd_word;
  logic [1:0]        rd_resp;
  logic [N_RO-1:0]   rd_hit;

  assign ar_hs  = S_AXI_arvalid && S_AXI_arready;
  assign ar_idx = S_AXI_araddr[IDX_W+1:2];

  // ctrl_q is read before this edge's write lands, so a same-edge read sees the old value.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_DECERR;
    rd_hit  = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = ctrl_q[i];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < N_RO; j++) begin
      if (ar_idx == IDX_W'(N_RW + j)) begin
        rd_word   = status_i[32*j +: 32];
        rd_resp   = RESP_OKAY;
        rd_hit[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rd_pulse_q <= '0;
      if (ar_hs) begin
        rvalid_q   <= 1'b1;
        rdata_q    <= rd_word;
        rresp_q    <= rd_resp;
        rd_pulse_q <= rd_hit;
      end else if (rvalid_q && S_AXI_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
module tb_axil_reg_slave;
  localparam int N_RW  = 8;
  localparam int N_RO  = 8;
  localparam int IDX_W = 10;

  logic               axi_clock = 1'b0;
  logic               rst;
  logic [31:0]        S_AXI_awaddr;
  logic [2:0]         S_AXI_awprot;
  logic               S_AXI_awvalid;
  logic               S_AXI_awready;
  logic [31:0]        S_AXI_wdata;
  logic [3:0]         S_AXI_wstrb;
  logic               S_AXI_wvalid;
  logic               S_AXI_wready;
  logic [1:0]         S_AXI_bresp;
  logic               S_AXI_bvalid;
  logic               S_AXI_bready;
  logic [31:0]        S_AXI_araddr;
  logic [2:0]         S_AXI_arprot;
  logic               S_AXI_arvalid;
  logic               S_AXI_arready;
  logic [31:0]        S_AXI_rdata;
  logic [1:0]         S_AXI_rresp;
  logic               S_AXI_rvalid;
  logic               S_AXI_rready;
  logic [N_RW*32-1:0] ctrl_o;
  logic [N_RW-1:0]    wr_pulse_o;
  logic [N_RO*32-1:0] status_i;
  logic [N_RO-1:0]    rd_pulse_o;

  always #5 axi_clock = ~axi_clock;

  axil_reg_slave #(.N_RW(N_RW), .N_RO(N_RO), .IDX_W(IDX_W)) dut (
    .axi_clock(axi_clock), .rst(rst),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
    .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .ctrl_o(ctrl_o), .wr_pulse_o(wr_pulse_o),
    .status_i(status_i), .rd_pulse_o(rd_pulse_o)
  );

  // Reference state: what the register file should hold, and the status words offered.
  logic [31:0] model_ctrl [N_RW];
  logic [31:0] status_w   [N_RO];
  for (genvar gj = 0; gj < N_RO; gj++) begin : g_st
    assign status_i[32*gj +: 32] = status_w[gj];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    int idx = idx_of(a);
    if (idx < N_RW) return 2'b00;
    if (idx < N_RW + N_RO) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check_ctrl_all(input string tag);
    for (int i = 0; i < N_RW; i++) check(tag, ctrl_o[32*i +: 32], model_ctrl[i]);
  endtask

  // All send_* tasks start and end on a negedge; the handshake is the posedge in between.
  task automatic send_aw(input logic [31:0] a);
    S_AXI_awaddr = a; S_AXI_awvalid = 1'b1;
    for (int n = 0; n < 50 && !S_AXI_awready; n++) @(negedge axi_clock);
    check("awready_wait", S_AXI_awready, 1'b1);
    @(posedge axi_clock); @(negedge axi_clock);
    S_AXI_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    S_AXI_wdata = d; S_AXI_wstrb = s; S_AXI_wvalid = 1'b1;
    for (int n = 0; n < 50 && !S_AXI_wready; n++) @(negedge axi_clock);
    check("wready_wait", S_AXI_wready, 1'b1);
    @(posedge axi_clock); @(negedge axi_clock);
    S_AXI_wvalid = 1'b0;
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AXI_awaddr = a; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = d; S_AXI_wstrb = s; S_AXI_wvalid = 1'b1;
    for (int n = 0; n < 50 && !(S_AXI_awready && S_AXI_wready); n++) @(negedge axi_clock);
    check("awwready_wait", {S_AXI_awready, S_AXI_wready}, 2'b11);
    @(posedge axi_clock); @(negedge axi_clock);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    S_AXI_araddr = a; S_AXI_arvalid = 1'b1;
    for (int n = 0; n < 50 && !S_AXI_arready; n++) @(negedge axi_clock);
    check("arready_wait", S_AXI_arready, 1'b1);
    @(posedge axi_clock); @(negedge axi_clock);
    S_AXI_arvalid = 1'b0;
  endtask

  // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int gap, input int hold);
    int idx = idx_of(a);
    logic [1:0] er = exp_wresp(a);
    logic [N_RW-1:0] ep = '0;
    logic [31:0] mask;
    @(negedge axi_clock);
    if (mode == 1) begin
      send_aw(a);
      repeat (gap) @(negedge axi_clock);
      check("b_early_aw", S_AXI_bvalid, 1'b0);
      check("awready_held", S_AXI_awready, 1'b0);
      send_w(d, s);
    end else if (mode == 2) begin
      send_w(d, s);
      repeat (gap) @(negedge axi_clock);
      check("b_early_w", S_AXI_bvalid, 1'b0);
      check("wready_held", S_AXI_wready, 1'b0);
      send_aw(a);
    end else begin
      send_aw_w(a, d, s);
    end
    if (er == 2'b00) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model_ctrl[idx] = (model_ctrl[idx] & ~mask) | (d & mask);
      ep[idx] = 1'b1;
    end
    check("bvalid", S_AXI_bvalid, 1'b1);
    check("bresp", S_AXI_bresp, er);
    check("wr_pulse", wr_pulse_o, ep);
    check_ctrl_all("ctrl_word");
    repeat (hold) begin
      @(negedge axi_clock);
      check("bvalid_stall", S_AXI_bvalid, 1'b1);
      check("wready_stall", {S_AXI_awready, S_AXI_wready}, 2'b00);
      check("bresp_stall", S_AXI_bresp, er);
      check("wr_pulse_stall", wr_pulse_o, '0);
    end
    S_AXI_bready = 1'b1;
    @(negedge axi_clock);
    S_AXI_bready = 1'b0;
    check("bvalid_clr", S_AXI_bvalid, 1'b0);
    check("wr_pulse_clr", wr_pulse_o, '0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, input bit rand_status);
    int idx = idx_of(a);
    logic [31:0] ed;
    logic [1:0] er;
    logic [N_RO-1:0] ep = '0;
    @(negedge axi_clock);
    if (rand_status) for (int j = 0; j < N_RO; j++) status_w[j] = $urandom;
    if (idx < N_RW) begin
      ed = model_ctrl[idx]; er = 2'b00;
    end else if (idx < N_RW + N_RO) begin
      ed = status_w[idx - N_RW]; er = 2'b00; ep[idx - N_RW] = 1'b1;
    end else begin
      ed = 32'h0; er = 2'b11;
    end
    send_ar(a);
    // Status moving after the sampling edge must not disturb the returned word.
    for (int j = 0; j < N_RO; j++) status_w[j] = $urandom;
    check("rvalid", S_AXI_rvalid, 1'b1);
    check("rdata", S_AXI_rdata, ed);
    check("rresp", S_AXI_rresp, er);
    check("rd_pulse", rd_pulse_o, ep);
    repeat (hold) begin
      @(negedge axi_clock);
      check("rvalid_stall", S_AXI_rvalid, 1'b1);
      check("arready_stall", S_AXI_arready, 1'b0);
      check("rdata_stall", S_AXI_rdata, ed);
      check("rd_pulse_stall", rd_pulse_o, '0);
    end
    S_AXI_rready = 1'b1;
    @(negedge axi_clock);
    S_AXI_rready = 1'b0;
    check("rvalid_clr", S_AXI_rvalid, 1'b0);
    check("rd_pulse_clr", rd_pulse_o, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 3);
    int idx;
    logic [31:0] hi = $urandom;
    if (sel <= 1) idx = $urandom_range(0, N_RW - 1);
    else if (sel == 2) idx = $urandom_range(N_RW, N_RW + N_RO - 1);
    else idx = $urandom_range(N_RW + N_RO, (1 << IDX_W) - 1);
    return (hi & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b0;
    S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
    for (int i = 0; i < N_RW; i++) model_ctrl[i] = '0;
    for (int j = 0; j < N_RO; j++) status_w[j] = '0;
    repeat (3) @(negedge axi_clock);
    rst = 1'b0;
    @(negedge axi_clock);

    check("rst_readies", {S_AXI_awready, S_AXI_wready, S_AXI_arready}, 3'b111);
    check("rst_valids", {S_AXI_bvalid, S_AXI_rvalid}, 2'b00);
    check("rst_rdata", S_AXI_rdata, 32'h0);
    check("rst_resps", {S_AXI_bresp, S_AXI_rresp}, 4'h0);
    check("rst_pulses", {wr_pulse_o, rd_pulse_o}, '0);
    check_ctrl_all("rst_ctrl");

    // AW first, W three edges later.
    axi_write(32'h04, 32'hA5A5_1234, 4'hF, 1, 2, 0);
    check("word1_direct", ctrl_o[63:32], 32'hA5A5_1234);

    // Partial strobes, W before AW then AW+W together.
    axi_write(32'h00, 32'hFFFF_FFFF, 4'b0101, 2, 2, 0);
    check("word0_wfirst", ctrl_o[31:0], 32'h00FF_00FF);
    axi_write(32'h00, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0);
    check("word0_together", ctrl_o[31:0], 32'h00FF_00FF);

    // Status read and write to a read-only word.
    status_w[0] = 32'hDEAD_BEEF;
    axi_read(32'h20, 0, 1'b0);
    axi_write(32'h20, 32'h1234_5678, 4'hF, 0, 0, 0);

    // Out of range.
    axi_read(32'h3FFC, 0, 1'b1);
    axi_write(32'h3FFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0);

    // Back-pressure on both response channels, then traffic resumes.
    axi_write(32'h08, 32'h1357_9BDF, 4'hF, 0, 0, 10);
    axi_read(32'h08, 10, 1'b1);
    axi_read(32'h2C, 0, 1'b1);

    // Same-edge read and write of one word returns the old value.
    fork
      axi_write(32'h0C, 32'h5555_AAAA, 4'hF, 0, 0, 0);
      axi_read(32'h0C, 0, 1'b1);
    join
    axi_read(32'h0C, 0, 1'b1);

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a = rand_addr();
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), 1'b1);
    end

    // Reset with an AW held and a read response pending.
    @(negedge axi_clock);
    S_AXI_awaddr = 32'h08; S_AXI_awvalid = 1'b1;
    S_AXI_araddr = 32'h24; S_AXI_arvalid = 1'b1;
    @(negedge axi_clock);
    S_AXI_awvalid = 1'b0; S_AXI_arvalid = 1'b0;
    check("pre_rst_aw_held", S_AXI_awready, 1'b0);
    check("pre_rst_r_pending", S_AXI_rvalid, 1'b1);
    rst = 1'b1;
    @(negedge axi_clock);
    rst = 1'b0;
    for (int i = 0; i < N_RW; i++) model_ctrl[i] = '0;
    check("mid_rst_readies", {S_AXI_awready, S_AXI_wready, S_AXI_arready}, 3'b111);
    check("mid_rst_valids", {S_AXI_bvalid, S_AXI_rvalid}, 2'b00);
    check("mid_rst_rdata", S_AXI_rdata, 32'h0);
    check("mid_rst_resps", {S_AXI_bresp, S_AXI_rresp}, 4'h0);
    check("mid_rst_pulses", {wr_pulse_o, rd_pulse_o}, '0);
    check_ctrl_all("mid_rst_ctrl");
    repeat (3) begin
      @(negedge axi_clock);
      check("post_rst_no_resp", {S_AXI_bvalid, S_AXI_rvalid}, 2'b00);
    end
    // The discarded AW must not pair with a fresh W.
    axi_write(32'h10, 32'h0BAD_C0DE, 4'hF, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
